// File: rtl/aurora_hls_pkg.sv
// Shared types and constants for the Aurora HLS link controller and monitor.
package aurora_hls_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PMA_RST = 3'd1,
        PB_RST  = 3'd2,
        WAIT_UP = 3'd3,
        UP      = 3'd4,
        FAILED  = 3'd5
    } link_state_t;

    localparam logic [12:0] STATUS_OK = 13'h11ff;

endpackage

// File: rtl/aurora_hls_debounce.sv
// Consecutive-cycle qualifier: o_stable asserts once i_cond has held DEBOUNCE cycles.
module aurora_hls_debounce #(
    parameter logic [15:0] DEBOUNCE = 16'd64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cond,
    input  logic i_clear,
    output logic o_stable
);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear || !i_cond) begin
            r_cnt <= '0;
        end else if (r_cnt != DEBOUNCE) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // The current cycle counts, so the decision fires when DEBOUNCE-1 are already banked.
    assign o_stable = i_cond && (r_cnt >= (DEBOUNCE - 16'd1));

endmodule

// File: rtl/aurora_hls_link_ctrl.sv
// Aurora bring-up/recovery sequencer. Optional statistics: AURORA_HLS_LINK_CTRL_STATS_EN.
//   state   | meaning
//   IDLE    | disabled, core held in reset
//   PMA_RST | pma_init asserted
//   PB_RST  | reset_pb asserted after pma_init release
//   WAIT_UP | waiting for debounced OK status, timeout -> retry
//   UP      | channel up, TX traffic allowed
//   FAILED  | retries exhausted, core held in reset
module aurora_hls_link_ctrl
    import aurora_hls_pkg::*;
#(
    parameter logic [31:0] PMA_INIT_CYCLES = 32'd1024,
    parameter logic [31:0] RESET_PB_CYCLES = 32'd256,
    parameter logic [31:0] LINK_TIMEOUT    = 32'd1000000,
    parameter logic [15:0] DEBOUNCE        = 16'd64,
    parameter logic [7:0]  MAX_RETRIES     = 8'd8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_reinit_req,
    input  logic [12:0] i_aurora_status,
    output logic        o_pma_init,
    output logic        o_reset_pb,
    output logic        o_tx_enable,
    output logic        o_link_up,
    output logic        o_failed,
    output logic [2:0]  o_state,
    output logic [7:0]  o_retry_count,
    output logic [31:0] o_link_down_count,
    output logic [31:0] o_up_cycles
);

    link_state_t r_state, w_next;
    logic [31:0] r_timer, w_timer_next;
    logic [7:0]  r_retry, w_retry_next;
    logic        w_ok, w_cond, w_stable, w_clear, w_loss;

    assign w_ok    = (i_aurora_status == STATUS_OK);
    assign w_clear = (w_next != r_state);

    always_comb begin
        w_cond = 1'b0;
        if (r_state == WAIT_UP) w_cond = w_ok;
        else if (r_state == UP) w_cond = !w_ok;
    end

    aurora_hls_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_cond   (w_cond),
        .i_clear  (w_clear),
        .o_stable (w_stable)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_next;
            r_retry <= w_retry_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_timer_next = r_timer;
        w_retry_next = r_retry;
        w_loss       = 1'b0;
        if (!i_enable) begin
            w_next       = IDLE;
            w_timer_next = '0;
            w_retry_next = '0;
        end else if (i_reinit_req && (r_state != IDLE)) begin
            w_next       = PMA_RST;
            w_timer_next = PMA_INIT_CYCLES - 32'd1;
            w_retry_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_next       = PMA_RST;
                    w_timer_next = PMA_INIT_CYCLES - 32'd1;
                end
                PMA_RST: begin
                    if (r_timer == '0) begin
                        w_next       = PB_RST;
                        w_timer_next = RESET_PB_CYCLES - 32'd1;
                    end else begin
                        w_timer_next = r_timer - 32'd1;
                    end
                end
                PB_RST: begin
                    if (r_timer == '0) begin
                        w_next       = WAIT_UP;
                        w_timer_next = LINK_TIMEOUT - 32'd1;
                    end else begin
                        w_timer_next = r_timer - 32'd1;
                    end
                end
                WAIT_UP: begin
                    if (w_stable) begin
                        w_next       = UP;
                        w_retry_next = '0;
                    end else if (r_timer == '0) begin
                        if (r_retry == (MAX_RETRIES - 8'd1)) begin
                            w_next       = FAILED;
                            w_retry_next = MAX_RETRIES;
                        end else begin
                            w_next       = PMA_RST;
                            w_timer_next = PMA_INIT_CYCLES - 32'd1;
                            w_retry_next = r_retry + 8'd1;
                        end
                    end else begin
                        w_timer_next = r_timer - 32'd1;
                    end
                end
                UP: begin
                    if (w_stable) begin
                        w_next       = PMA_RST;
                        w_timer_next = PMA_INIT_CYCLES - 32'd1;
                        w_loss       = 1'b1;
                    end
                end
                FAILED: begin
                end
                default: begin
                    w_next       = IDLE;
                    w_timer_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_pma_init  = 1'b0;
        o_reset_pb  = 1'b0;
        o_tx_enable = 1'b0;
        o_link_up   = 1'b0;
        o_failed    = 1'b0;
        case (r_state)
            IDLE, PMA_RST: begin
                o_pma_init = 1'b1;
                o_reset_pb = 1'b1;
            end
            PB_RST: o_reset_pb = 1'b1;
            UP: begin
                o_tx_enable = 1'b1;
                o_link_up   = 1'b1;
            end
            FAILED: begin
                o_pma_init = 1'b1;
                o_reset_pb = 1'b1;
                o_failed   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_state       = r_state;
    assign o_retry_count = r_retry;

`ifdef AURORA_HLS_LINK_CTRL_STATS_EN
    logic [31:0] r_link_down_count, r_up_cycles;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_link_down_count <= '0;
            r_up_cycles       <= '0;
        end else begin
            if (w_loss && (r_link_down_count != 32'hFFFF_FFFF))
                r_link_down_count <= r_link_down_count + 32'd1;
            if ((r_state == UP) && (r_up_cycles != 32'hFFFF_FFFF))
                r_up_cycles <= r_up_cycles + 32'd1;
        end
    end

    assign o_link_down_count = r_link_down_count;
    assign o_up_cycles       = r_up_cycles;
`else
    assign o_link_down_count = 32'd0;
    assign o_up_cycles       = 32'd0;
`endif

endmodule

// File: tb/tb_aurora_hls_link_ctrl.sv
// Self-checking bench for aurora_hls_link_ctrl: directed table, corner sequences, random vs model.
module tb_aurora_hls_link_ctrl;

    localparam int PMA = 4;
    localparam int PB  = 2;
    localparam int TO  = 10;
    localparam int DEB = 3;
    localparam int MAXR = 2;
    localparam logic [12:0] OK = 13'h11ff;
`ifdef AURORA_HLS_LINK_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, reinit;
    logic [12:0] status;
    logic        pma_init, reset_pb, tx_enable, link_up, failed;
    logic [2:0]  state;
    logic [7:0]  retry_count;
    logic [31:0] link_down_count, up_cycles;

    aurora_hls_link_ctrl #(
        .PMA_INIT_CYCLES (32'(PMA)),
        .RESET_PB_CYCLES (32'(PB)),
        .LINK_TIMEOUT    (32'(TO)),
        .DEBOUNCE        (16'(DEB)),
        .MAX_RETRIES     (8'(MAXR))
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_enable          (en),
        .i_reinit_req      (reinit),
        .i_aurora_status   (status),
        .o_pma_init        (pma_init),
        .o_reset_pb        (reset_pb),
        .o_tx_enable       (tx_enable),
        .o_link_up         (link_up),
        .o_failed          (failed),
        .o_state           (state),
        .o_retry_count     (retry_count),
        .o_link_down_count (link_down_count),
        .o_up_cycles       (up_cycles)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phase number, cycles spent in the phase, length of the current
    // qualifying status run, and event counters.
    int m_state, m_age, m_run, m_retry, m_ldc, m_up;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_age = 0; m_run = 0; m_retry = 0; m_ldc = 0; m_up = 0;
    endtask

    task automatic model_step();
        int nxt, run;
        bit moved, ok;
        ok = (status == OK);
        nxt = m_state;
        moved = 1'b0;
        run = 0;
        if (m_state == 4) m_up++;
        if (!en) begin
            nxt = 0; moved = 1'b1; m_retry = 0;
        end else if (reinit && m_state != 0) begin
            nxt = 1; moved = 1'b1; m_retry = 0;
        end else begin
            case (m_state)
                0: begin nxt = 1; moved = 1'b1; end
                1: if (m_age == PMA - 1) begin nxt = 2; moved = 1'b1; end
                2: if (m_age == PB - 1) begin nxt = 3; moved = 1'b1; end
                3: begin
                    run = ok ? m_run + 1 : 0;
                    if (run >= DEB) begin
                        nxt = 4; moved = 1'b1; m_retry = 0;
                    end else if (m_age == TO - 1) begin
                        moved = 1'b1;
                        if (m_retry == MAXR - 1) begin nxt = 5; m_retry = MAXR; end
                        else begin nxt = 1; m_retry++; end
                    end
                end
                4: begin
                    run = !ok ? m_run + 1 : 0;
                    if (run >= DEB) begin
                        nxt = 1; moved = 1'b1;
                        if (STATS) m_ldc++;
                    end
                end
                default: ;
            endcase
        end
        if (moved) begin m_age = 0; m_run = 0; end
        else begin m_age++; m_run = run; end
        m_state = nxt;
    endtask

    task automatic check_model();
        chk("model state", state, m_state);
        chk("model pma_init", pma_init, (m_state == 0 || m_state == 1 || m_state == 5));
        chk("model reset_pb", reset_pb, (m_state != 3 && m_state != 4));
        chk("model tx_enable", tx_enable, (m_state == 4));
        chk("model link_up", link_up, (m_state == 4));
        chk("model failed", failed, (m_state == 5));
        chk("model retry_count", retry_count, m_retry);
        chk("model link_down_count", link_down_count, m_ldc);
        chk("model up_cycles", up_cycles, STATS ? m_up : 0);
    endtask

    task automatic tick(input bit e, input bit r, input logic [12:0] s);
        en = e; reinit = r; status = s;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " state"}, state, 0);
        chk({tag, " pma_init"}, pma_init, 1);
        chk({tag, " reset_pb"}, reset_pb, 1);
        chk({tag, " tx_enable"}, tx_enable, 0);
        chk({tag, " link_up"}, link_up, 0);
        chk({tag, " failed"}, failed, 0);
        chk({tag, " retry_count"}, retry_count, 0);
        chk({tag, " link_down_count"}, link_down_count, 0);
        chk({tag, " up_cycles"}, up_cycles, 0);
    endtask

    typedef struct {
        bit          e;
        bit          r;
        logic [12:0] s;
        int          st;
        bit          pma;
        bit          pb;
        bit          lu;
    } vec_t;

    function automatic vec_t mk(bit e, bit r, logic [12:0] s, int st, bit pma, bit pb, bit lu);
        vec_t v;
        v.e = e; v.r = r; v.s = s; v.st = st; v.pma = pma; v.pb = pb; v.lu = lu;
        return v;
    endfunction

    vec_t tbl[18];
    bit   seen1;

    initial begin
        // Bring-up: 4 cycles PMA_RST, 2 PB_RST, 3 WAIT_UP, then UP; then glitch handling.
        for (int i = 0; i < 4; i++) tbl[i] = mk(1, 0, OK, 1, 1, 1, 0);
        for (int i = 4; i < 6; i++) tbl[i] = mk(1, 0, OK, 2, 0, 1, 0);
        for (int i = 6; i < 9; i++) tbl[i] = mk(1, 0, OK, 3, 0, 0, 0);
        for (int i = 9; i < 12; i++) tbl[i] = mk(1, 0, OK, 4, 0, 0, 1);
        tbl[12] = mk(1, 0, 13'h0, 4, 0, 0, 1);
        tbl[13] = mk(1, 0, 13'h0, 4, 0, 0, 1);
        tbl[14] = mk(1, 0, OK, 4, 0, 0, 1);
        tbl[15] = mk(1, 0, 13'h0, 4, 0, 0, 1);
        tbl[16] = mk(1, 0, 13'h0, 4, 0, 0, 1);
        tbl[17] = mk(1, 0, 13'h0, 1, 1, 1, 0);

        rst = 1'b1; en = 1'b0; reinit = 1'b0; status = 13'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].e, tbl[i].r, tbl[i].s);
            chk($sformatf("tbl[%0d] state", i), state, tbl[i].st);
            chk($sformatf("tbl[%0d] pma_init", i), pma_init, tbl[i].pma);
            chk($sformatf("tbl[%0d] reset_pb", i), reset_pb, tbl[i].pb);
            chk($sformatf("tbl[%0d] link_up", i), link_up, tbl[i].lu);
            chk($sformatf("tbl[%0d] tx_enable", i), tx_enable, tbl[i].lu);
        end
        chk("glitch link_down_count", link_down_count, STATS ? 1 : 0);

        // Timeout: two failed attempts end in FAILED.
        seen1 = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick(1, 0, 13'h0);
            if (retry_count == 8'd1) seen1 = 1'b1;
            if (state == 3'd5) break;
        end
        chk("timeout saw retry_count 1", seen1, 1);
        chk("timeout state", state, 5);
        chk("timeout retry_count", retry_count, 2);
        chk("timeout failed", failed, 1);
        chk("timeout pma_init", pma_init, 1);
        repeat (5) tick(1, 0, 13'h0);
        chk("failed sticky", state, 5);

        // Priority: reinit from FAILED, then enable=0 beats reinit while UP.
        tick(1, 1, OK);
        chk("reinit from failed state", state, 1);
        chk("reinit from failed retry_count", retry_count, 0);
        for (int k = 0; k < 100; k++) begin
            tick(1, 0, OK);
            if (state == 3'd4) break;
        end
        chk("reach up again", state, 4);
        tick(0, 1, OK);
        chk("enable0 over reinit state", state, 0);
        chk("enable0 over reinit pma_init", pma_init, 1);
        chk("enable0 over reinit link_up", link_up, 0);

        // Asynchronous reset in the middle of PB_RST.
        for (int k = 0; k < 100; k++) begin
            tick(1, 0, OK);
            if (state == 3'd2) break;
        end
        chk("reach pb_rst", state, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("async reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic against the model.
        begin
            bit ok_mode;
            logic [12:0] s;
            ok_mode = 1'b1;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(0, 24) == 0) ok_mode = !ok_mode;
                if (ok_mode) s = ($urandom_range(0, 39) == 0) ? 13'h0 : OK;
                else s = 13'($urandom);
                tick($urandom_range(0, 199) != 0, $urandom_range(0, 149) == 0, s);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
